// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the 8-way round-robin arbiter.
package rr_arb_pkg;
   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) scanning
// upward from start, wrapping past the top index.
module rr_pick
   import rr_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [IDX_W-1:0] start,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0]   cand;
   logic [2*N_REQ-1:0] cand_dbl;
   logic [2*N_REQ-1:0] cand_shift;
   logic [N_REQ-1:0]   cand_rot;
   logic [IDX_W-1:0]   offset;

   // Rotating the doubled vector puts bit 'start' at position 0, so the
   // lowest set bit of the rotated vector is the round-robin winner.
   assign cand       = req & mask;
   assign cand_dbl   = {cand, cand};
   assign cand_shift = cand_dbl >> start;
   assign cand_rot   = cand_shift[N_REQ-1:0];

   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (cand_rot[i]) begin
            found  = 1'b1;
            offset = IDX_W'(i);
         end
      end
   end

   assign idx = start + offset;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and an
// optional hold limit that rotates ownership when others are waiting.
module rr_arbiter8
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   // With no limit the counter just parks at 1; it is never compared.
   localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD) : CNT_W'(1);
   localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

   state_e           state_q,    state_d;
   logic [N_REQ-1:0] gnt_q,      gnt_d;
   logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [IDX_W-1:0] last_q,     last_d;

   logic [N_REQ-1:0] owner_mask;
   logic [N_REQ-1:0] pick_mask;
   logic [IDX_W-1:0] pick_start;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             owner_req;
   logic             others_pending;
   logic             hold_hit;

   assign owner_mask     = ~(ONE << gnt_idx_q);
   assign pick_mask      = (state_q == BUSY) ? owner_mask : '1;
   assign pick_start     = last_q + IDX_W'(1);
   assign owner_req      = req[gnt_idx_q];
   assign others_pending = |(req & owner_mask);
   assign hold_hit       = (MAX_HOLD > 0) && (hold_cnt_q == HOLD_SAT);

   rr_pick u_pick (
      .req   (req),
      .mask  (pick_mask),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      hold_cnt_d  = hold_cnt_q;
      last_d      = last_q;

      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            if (pick_found) begin
               state_d     = BUSY;
               gnt_d       = ONE << pick_idx;
               gnt_idx_d   = pick_idx;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = CNT_W'(1);
               last_d      = pick_idx;
            end
         end
         BUSY: begin
            // Release and hold-limit revoke share one path; the owner bit is
            // masked so a still-requesting owner cannot win its own revoke.
            if (!owner_req || (hold_hit && others_pending)) begin
               if (pick_found) begin
                  gnt_d       = ONE << pick_idx;
                  gnt_idx_d   = pick_idx;
                  gnt_valid_d = 1'b1;
                  hold_cnt_d  = CNT_W'(1);
                  last_d      = pick_idx;
               end else begin
                  state_d     = IDLE;
                  gnt_d       = '0;
                  gnt_valid_d = 1'b0;
                  hold_cnt_d  = '0;
               end
            end else if (hold_cnt_q != HOLD_SAT) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         hold_cnt_q  <= '0;
         last_q      <= IDX_W'(N_REQ - 1);
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         hold_cnt_q  <= hold_cnt_d;
         last_q      <= last_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: a behavioural owner/last/hold-count model
// checked every cycle, plus literal expectations at key points.
module tb_rr_arbiter8;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] req = 8'h00;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_owner = -1;
   int m_last  = 7;
   int m_cnt   = 0;
   int m_idx   = 0;
   bit m_live  = 1'b0;

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic int find_next(input logic [7:0] v, input int from);
      for (int k = 1; k <= 8; k++) begin
         int i;
         i = (from + k) % 8;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic grant_to(input int w);
      m_owner = w;
      m_last  = w;
      m_idx   = w;
      m_cnt   = 1;
   endtask

   always @(posedge clk) begin
      if (rst) begin
         m_owner = -1;
         m_last  = 7;
         m_cnt   = 0;
         m_idx   = 0;
         m_live  = 1'b1;
      end else if (m_live) begin
         if (m_owner < 0) begin
            int w;
            w = find_next(req, m_last);
            if (w >= 0) grant_to(w);
         end else begin
            logic [7:0] others;
            bit         revoke;
            int         w;
            others = req;
            others[m_owner] = 1'b0;
            revoke = !req[m_owner] || (MH > 0 && m_cnt >= MH && others != 8'h00);
            if (revoke) begin
               w = find_next(others, m_last);
               if (w >= 0) grant_to(w);
               else begin
                  m_owner = -1;
                  m_cnt   = 0;
               end
            end else if (m_cnt < MH) begin
               m_cnt++;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         logic [7:0] exp_gnt;
         exp_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
         chk("model_gnt", 32'(gnt), 32'(exp_gnt));
         chk("model_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         chk("model_idx", 32'(gnt_idx), 32'(m_idx));
         chk("onehot", 32'($countones(gnt) <= 1 && gnt_valid == |gnt), 32'd1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e;
      rst = 1'b1;
      req = 8'h00;
      tick();
      tick();
      chk("reset_gnt", 32'(gnt), 32'h00);
      chk("reset_valid", 32'(gnt_valid), 32'd0);
      chk("reset_idx", 32'(gnt_idx), 32'd0);
      rst = 1'b0;

      // no requests: stays idle
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_gnt", 32'(gnt), 32'h00);
         chk("idle_valid", 32'(gnt_valid), 32'd0);
      end

      // all request, each owner releases after two cycles
      req = 8'hFF;
      tick();
      for (int k = 0; k <= 8; k++) begin
         e = k % 8;
         chk("rr_order", 32'(gnt), 32'(8'h01 << e));
         tick();
         chk("rr_hold", 32'(gnt), 32'(8'h01 << e));
         req[e] = 1'b0;
         tick();
         req[e] = 1'b1;
      end
      chk("rr_after", 32'(gnt), 32'h02);
      req = 8'h00;
      tick();
      chk("rr_drain", 32'(gnt), 32'h00);

      // establish last=3, then req 0x14 must pick idx 4
      req = 8'h08;
      tick();
      chk("last3_gnt", 32'(gnt), 32'h08);
      req = 8'h00;
      tick();
      req = 8'h14;
      tick();
      chk("scan_gnt", 32'(gnt), 32'h10);
      chk("scan_idx", 32'(gnt_idx), 32'd4);
      req = 8'h00;
      tick();

      // hold limit: req[2] forever, req[5] joins at its second grant cycle
      req = 8'h04;
      tick();
      chk("hold_c1", 32'(gnt), 32'h04);
      tick();
      chk("hold_c2", 32'(gnt), 32'h04);
      req = 8'h24;
      tick();
      chk("hold_c3", 32'(gnt), 32'h04);
      tick();
      chk("hold_c4", 32'(gnt), 32'h04);
      tick();
      chk("revoke_gnt", 32'(gnt), 32'h20);
      tick();
      chk("revoke_hold", 32'(gnt), 32'h20);
      req = 8'h04;
      tick();
      chk("return_gnt", 32'(gnt), 32'h04);

      // lone requester keeps the grant past the limit
      req = 8'h00;
      tick();
      req = 8'h40;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("lone_hold", 32'(gnt), 32'h40);
      end

      // reset mid-grant
      req = 8'h08;
      tick();
      chk("pre_rst_gnt", 32'(gnt), 32'h08);
      rst = 1'b1;
      tick();
      chk("mid_rst_gnt", 32'(gnt), 32'h00);
      chk("mid_rst_valid", 32'(gnt_valid), 32'd0);
      rst = 1'b0;
      req = 8'hFF;
      tick();
      chk("post_rst_gnt", 32'(gnt), 32'h01);
      chk("post_rst_idx", 32'(gnt_idx), 32'd0);

      // all requesting and nobody releasing: rotate every MH cycles
      for (int i = 0; i < 12; i++) tick();
      chk("rotate_gnt", 32'(gnt), 32'h08);

      req = 8'h00;
      tick();
      tick();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
